// File: rtl/mode_hub_pkg.sv
// mode_hub_pkg: mode/field encodings and saturating clamps shared by the parameter hub
package mode_hub_pkg;
  typedef enum logic [1:0] {
    MODE_ANGLE_DEMANDED = 2'd0,
    MODE_SINE           = 2'd1,
    MODE_K_VIS_FRIC     = 2'd2
  } mode_t;
  typedef enum logic {
    EDIT_AMPLITUDE = 1'b0,
    EDIT_FREQUENCY = 1'b1
  } field_t;
  function automatic int clamp_signed(int v, int lim);
    return v > lim ? lim : v < -lim ? -lim : v;
  endfunction
  function automatic int clamp_unsigned(int v, int lo, int hi);
    return v > hi ? hi : v < lo ? lo : v;
  endfunction
endpackage

// File: rtl/button_repeater.sv
// button_repeater: press edge step plus hold-to-repeat with accelerated (fast) repeats
// Ports: clk_i, reset_i (sync, high); clear_i forces idle; btn_i debounced level;
//   step_o one-cycle step request; fast_o qualifies step_o as a fast-phase step
module button_repeater #(
  parameter int HOLD_CYCLES   = 500000,
  parameter int REPEAT_CYCLES = 100000,
  parameter int FAST_AFTER    = 8
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic clear_i,
  input  logic btn_i,
  output logic step_o,
  output logic fast_o
);
  localparam int CW = $clog2((HOLD_CYCLES > REPEAT_CYCLES ? HOLD_CYCLES : REPEAT_CYCLES) + 1);
  localparam int RW = $clog2(FAST_AFTER + 1) + 1;
  logic prev, active, repeating, edge_hit, period_hit;
  logic [CW-1:0] cnt;
  logic [RW-1:0] rep;
  assign edge_hit = btn_i & ~prev;
  assign period_hit = active & btn_i & (cnt == (repeating ? CW'(REPEAT_CYCLES) : CW'(HOLD_CYCLES)));
  assign step_o = ~clear_i & (edge_hit | period_hit);
  assign fast_o = period_hit & (rep == RW'(FAST_AFTER));
  // prev keeps tracking while cleared so a level held through the clear never looks like a fresh press
  always_ff @(posedge clk_i)
    if (reset_i) begin
      prev <= 1'b0;
      active <= 1'b0;
      repeating <= 1'b0;
      cnt <= '0;
      rep <= '0;
    end else begin
      prev <= btn_i;
      if (clear_i || !btn_i) begin
        active <= 1'b0;
        repeating <= 1'b0;
        cnt <= '0;
        rep <= '0;
      end else if (edge_hit) begin
        active <= 1'b1;
        repeating <= 1'b0;
        cnt <= CW'(1);
        rep <= '0;
      end else if (period_hit) begin
        repeating <= 1'b1;
        cnt <= CW'(1);
        rep <= rep == RW'(FAST_AFTER) ? rep : rep + 1'b1;
      end else if (active) begin
        cnt <= cnt + 1'b1;
      end
    end
endmodule

// File: rtl/mode_hub_v2.sv
// mode_hub_v2: operator parameter hub holding per-mode setpoints edited with four buttons
// Ports: clk_i, reset_i (sync, high); enable_i gates all buttons; button_*_i debounced levels;
//   mode_o/field_o current edit target; angle/ampl/freq/k setpoints; update_o change strobe
module mode_hub_v2
  import mode_hub_pkg::*;
#(
  parameter int ANGLE_W       = 9,
  parameter int ANGLE_MAX     = 255,
  parameter int AMP_W         = 6,
  parameter int AMP_MAX       = 37,
  parameter int FREQ_W        = 4,
  parameter int FREQ_MIN      = 1,
  parameter int FREQ_RESET    = 2,
  parameter int K_W           = 8,
  parameter int K_RESET       = 16,
  parameter int HOLD_CYCLES   = 500000,
  parameter int REPEAT_CYCLES = 100000,
  parameter int FAST_AFTER    = 8,
  parameter int FAST_STEP     = 10
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      enable_i,
  input  logic                      button_mode_i,
  input  logic                      button_field_i,
  input  logic                      button_plus_i,
  input  logic                      button_minus_i,
  output logic [1:0]                mode_o,
  output logic                      field_o,
  output logic signed [ANGLE_W-1:0] angle_demanded_o,
  output logic [AMP_W-1:0]          ampl_sine_demanded_o,
  output logic [FREQ_W-1:0]         cnt_freq_sine_demanded_o,
  output logic [K_W-1:0]            k_vis_fric_o,
  output logic                      update_o
);
  localparam int FREQ_MAX = 2 ** FREQ_W - 1;
  localparam int K_MAX = 2 ** K_W - 1;
  mode_t mode, mode_n;
  field_t field, field_n;
  logic signed [ANGLE_W-1:0] angle, angle_n;
  logic [AMP_W-1:0] ampl, ampl_n;
  logic [FREQ_W-1:0] freq, freq_n;
  logic [K_W-1:0] k, k_n;
  logic update, update_n, prev_mode, prev_field, mode_edge, field_edge, clear;
  logic p_step, p_fast, m_step, m_fast, fast;
  int delta, amp_sum;
  assign mode_edge = enable_i & button_mode_i & ~prev_mode;
  assign field_edge = enable_i & button_field_i & ~prev_field;
  // both buttons, a mode change or a disabled hub drop the repeaters to idle; only a fresh press restarts them
  assign clear = ~enable_i | (button_plus_i & button_minus_i) | mode_edge;
  button_repeater #(
    .HOLD_CYCLES(HOLD_CYCLES),
    .REPEAT_CYCLES(REPEAT_CYCLES),
    .FAST_AFTER(FAST_AFTER)
  ) plus_rep (
    .clk_i(clk_i),
    .reset_i(reset_i),
    .clear_i(clear),
    .btn_i(button_plus_i),
    .step_o(p_step),
    .fast_o(p_fast)
  );
  button_repeater #(
    .HOLD_CYCLES(HOLD_CYCLES),
    .REPEAT_CYCLES(REPEAT_CYCLES),
    .FAST_AFTER(FAST_AFTER)
  ) minus_rep (
    .clk_i(clk_i),
    .reset_i(reset_i),
    .clear_i(clear),
    .btn_i(button_minus_i),
    .step_o(m_step),
    .fast_o(m_fast)
  );
  // sums are formed in int so the clamp sees the true value before it is narrowed back
  always_comb begin
    fast = p_step ? p_fast : m_fast;
    delta = p_step ? (p_fast ? FAST_STEP : 1) : m_step ? -(m_fast ? FAST_STEP : 1) : 0;
    amp_sum = int'(ampl) + delta;
    mode_n = !(mode inside {MODE_ANGLE_DEMANDED, MODE_SINE, MODE_K_VIS_FRIC}) ? MODE_ANGLE_DEMANDED :
             !mode_edge ? mode :
             mode == MODE_ANGLE_DEMANDED ? MODE_SINE :
             mode == MODE_SINE ? MODE_K_VIS_FRIC : MODE_ANGLE_DEMANDED;
    field_n = mode_n != mode ? EDIT_AMPLITUDE :
              field_edge && mode == MODE_SINE ? field_t'(~field) : field;
    angle_n = delta != 0 && mode == MODE_ANGLE_DEMANDED ?
              ANGLE_W'(clamp_signed(int'(angle) + delta, ANGLE_MAX)) : angle;
    ampl_n = delta != 0 && mode == MODE_SINE && field == EDIT_AMPLITUDE ?
             AMP_W'(fast ? clamp_unsigned(amp_sum, 0, AMP_MAX) :
                    amp_sum > AMP_MAX ? 0 : amp_sum < 0 ? AMP_MAX : amp_sum) : ampl;
    freq_n = delta != 0 && mode == MODE_SINE && field == EDIT_FREQUENCY ?
             FREQ_W'(clamp_unsigned(int'(freq) + delta, FREQ_MIN, FREQ_MAX)) : freq;
    k_n = delta != 0 && mode == MODE_K_VIS_FRIC ?
          K_W'(clamp_unsigned(int'(k) + delta, 0, K_MAX)) : k;
    update_n = {mode_n, field_n, angle_n, ampl_n, freq_n, k_n} != {mode, field, angle, ampl, freq, k};
  end
  always_ff @(posedge clk_i)
    if (reset_i) begin
      mode <= MODE_ANGLE_DEMANDED;
      field <= EDIT_AMPLITUDE;
      angle <= '0;
      ampl <= '0;
      freq <= FREQ_W'(FREQ_RESET);
      k <= K_W'(K_RESET);
      update <= 1'b0;
      prev_mode <= 1'b0;
      prev_field <= 1'b0;
    end else begin
      mode <= mode_n;
      field <= field_n;
      angle <= angle_n;
      ampl <= ampl_n;
      freq <= freq_n;
      k <= k_n;
      update <= update_n;
      prev_mode <= button_mode_i;
      prev_field <= button_field_i;
    end
  assign mode_o = mode;
  assign field_o = field;
  assign angle_demanded_o = angle;
  assign ampl_sine_demanded_o = ampl;
  assign cnt_freq_sine_demanded_o = freq;
  assign k_vis_fric_o = k;
  assign update_o = update;
endmodule

// File: tb/tb_mode_hub_v2.sv
// tb_mode_hub_v2: randomized and directed checks of mode_hub_v2 against a cycle-age reference model
module tb_mode_hub_v2;
  localparam int HOLD = 20, REP = 5, FAST = 3, FSTEP = 10;
  logic clk = 1'b0;
  logic rst = 1'b1, en = 1'b1, bm = 1'b0, bf = 1'b0, bp = 1'b0, bn = 1'b0;
  logic [1:0] mode;
  logic field, upd;
  logic [8:0] angle;
  logic [5:0] ampl;
  logic [3:0] freq;
  logic [7:0] k;
  logic [30:0] obs;
  int passed = 0, total = 0, pulses = 0;
  int m_mode = 0, m_field = 0, m_angle = 0, m_amp = 0, m_freq = 2, m_k = 16;
  bit m_upd = 0, pv_m = 0, pv_f = 0, pv_p = 0, pv_n = 0;
  int age_p = -1, age_n = -1;

  always #5 clk = ~clk;

  mode_hub_v2 #(.HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP), .FAST_AFTER(FAST), .FAST_STEP(FSTEP)) dut (
    .clk_i(clk), .reset_i(rst), .enable_i(en), .button_mode_i(bm), .button_field_i(bf),
    .button_plus_i(bp), .button_minus_i(bn), .mode_o(mode), .field_o(field),
    .angle_demanded_o(angle), .ampl_sine_demanded_o(ampl), .cnt_freq_sine_demanded_o(freq),
    .k_vis_fric_o(k), .update_o(upd)
  );

  assign obs = {mode, field, angle, ampl, freq, k, upd};

  function automatic int sat(int v, int lo, int hi);
    return v > hi ? hi : v < lo ? lo : v;
  endfunction

  function automatic logic [30:0] expv();
    return {2'(m_mode), 1'(m_field), 9'(m_angle), 6'(m_amp), 4'(m_freq), 8'(m_k), m_upd};
  endfunction

  // age = cycles since the press edge; steps fall at age 0 and at HOLD + j*REP, fast once j >= FAST
  task automatic rep_model(input bit b, input bit pv, input bit clr, inout int age, output bit st, output bit fs);
    st = 0;
    fs = 0;
    if (clr || !b) age = -1;
    else if (!pv) begin
      age = 0;
      st = 1;
    end else if (age >= 0) begin
      age++;
      if (age >= HOLD && (age - HOLD) % REP == 0) begin
        st = 1;
        fs = (age - HOLD) / REP >= FAST;
      end
    end
  endtask

  task automatic model_edge();
    bit me, fe, clr, sp, sn, fp, fn;
    int d, o_mode, o_field, o_angle, o_amp, o_freq, o_k;
    if (rst) begin
      m_mode = 0; m_field = 0; m_angle = 0; m_amp = 0; m_freq = 2; m_k = 16; m_upd = 0;
      pv_m = 0; pv_f = 0; pv_p = 0; pv_n = 0; age_p = -1; age_n = -1;
      return;
    end
    me = en && bm && !pv_m;
    fe = en && bf && !pv_f;
    clr = !en || (bp && bn) || me;
    rep_model(bp, pv_p, clr, age_p, sp, fp);
    rep_model(bn, pv_n, clr, age_n, sn, fn);
    o_mode = m_mode; o_field = m_field; o_angle = m_angle; o_amp = m_amp; o_freq = m_freq; o_k = m_k;
    d = sp ? (fp ? FSTEP : 1) : sn ? -(fn ? FSTEP : 1) : 0;
    if (d != 0) begin
      if (m_mode == 0) m_angle = sat(m_angle + d, -255, 255);
      else if (m_mode == 1 && m_field == 0) begin
        m_amp = m_amp + d;
        if (d == 1 || d == -1) m_amp = m_amp > 37 ? 0 : m_amp < 0 ? 37 : m_amp;
        else m_amp = sat(m_amp, 0, 37);
      end else if (m_mode == 1) m_freq = sat(m_freq + d, 1, 15);
      else m_k = sat(m_k + d, 0, 255);
    end
    if (me) begin
      m_mode = (m_mode + 1) % 3;
      m_field = 0;
    end else if (fe && m_mode == 1) m_field = 1 - m_field;
    m_upd = o_mode != m_mode || o_field != m_field || o_angle != m_angle ||
            o_amp != m_amp || o_freq != m_freq || o_k != m_k;
    pv_m = bm; pv_f = bf; pv_p = bp; pv_n = bn;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    if (upd === 1'b1) pulses++;
  endtask

  task automatic test_reset();
    rst = 1;
    tick();
    {bm, bf, bp, bn} = 4'hf;
    for (int i = 0; i < 6; i++) begin
      tick();
      total++;
      if (obs !== {2'd0, 1'b0, 9'd0, 6'd0, 4'd2, 8'd16, 1'b0})
        $display("FAIL reset_hold cyc%0d: got %h want %h", i, obs, {2'd0, 1'b0, 9'd0, 6'd0, 4'd2, 8'd16, 1'b0});
      else passed++;
    end
    {bm, bf, bp, bn} = 4'h0;
    tick();
    rst = 0;
    tick();
    total++;
    if (obs !== expv()) $display("FAIL reset_release: got %h want %h", obs, expv());
    else passed++;
  endtask

  task automatic test_angle_repeat();
    bp = 1;
    pulses = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      total++;
      if (obs !== expv()) $display("FAIL angle_hold cyc%0d: got %h want %h", i, obs, expv());
      else passed++;
    end
    total++;
    if (pulses !== 9) $display("FAIL angle_hold_pulses: got %0d want 9", pulses);
    else passed++;
    total++;
    if (angle !== 9'd54) $display("FAIL angle_hold_value: got %0d want 54", $signed(angle));
    else passed++;
    bp = 0;
    tick();
    bn = 1;
    tick();
    bn = 0;
    tick();
    total++;
    if (angle !== 9'd53 || obs !== expv()) $display("FAIL angle_minus_pulse: got %h want %h", obs, expv());
    else passed++;
  endtask

  task automatic test_angle_clamp();
    bp = 1;
    for (int i = 0; i < 200; i++) begin
      if (i == 170) pulses = 0;
      tick();
      total++;
      if (obs !== expv()) $display("FAIL clamp_hi cyc%0d: got %h want %h", i, obs, expv());
      else passed++;
    end
    total++;
    if (angle !== 9'd255 || pulses !== 0) $display("FAIL clamp_hi_hold: got %0d pulses %0d want 255 pulses 0", $signed(angle), pulses);
    else passed++;
    bp = 0;
    tick();
    bn = 1;
    for (int i = 0; i < 400; i++) begin
      if (i == 370) pulses = 0;
      tick();
      total++;
      if (obs !== expv()) $display("FAIL clamp_lo cyc%0d: got %h want %h", i, obs, expv());
      else passed++;
    end
    total++;
    if ($signed(angle) !== -255 || pulses !== 0) $display("FAIL clamp_lo_hold: got %0d pulses %0d want -255 pulses 0", $signed(angle), pulses);
    else passed++;
    bn = 0;
    tick();
  endtask

  task automatic test_sine();
    bm = 1;
    tick();
    bm = 0;
    tick();
    total++;
    if (mode !== 2'd1 || obs !== expv()) $display("FAIL sine_enter: got %h want %h", obs, expv());
    else passed++;
    bn = 1; tick(); bn = 0; tick();
    total++;
    if (ampl !== 6'd37) $display("FAIL amp_wrap_down: got %0d want 37", ampl);
    else passed++;
    bp = 1; tick(); bp = 0; tick();
    total++;
    if (ampl !== 6'd0) $display("FAIL amp_wrap_up: got %0d want 0", ampl);
    else passed++;
    bn = 1; tick(); bn = 0; tick();
    total++;
    if (ampl !== 6'd37 || obs !== expv()) $display("FAIL amp_wrap_down2: got %h want %h", obs, expv());
    else passed++;
    bf = 1; tick(); bf = 0; tick();
    total++;
    if (field !== 1'b1) $display("FAIL field_toggle: got %0d want 1", field);
    else passed++;
    pulses = 0;
    for (int i = 0; i < 2; i++) begin
      bn = 1; tick(); bn = 0; tick();
    end
    total++;
    if (freq !== 4'd1 || pulses !== 1) $display("FAIL freq_floor: got %0d pulses %0d want 1 pulses 1", freq, pulses);
    else passed++;
  endtask

  task automatic test_mode_override();
    bm = 1;
    bp = 1;
    pulses = 0;
    tick();
    bm = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      total++;
      if (obs !== expv()) $display("FAIL override cyc%0d: got %h want %h", i, obs, expv());
      else passed++;
    end
    total++;
    if (mode !== 2'd2 || field !== 1'b0 || k !== 8'd16 || pulses !== 1)
      $display("FAIL override_state: got mode %0d field %0d k %0d pulses %0d want 2 0 16 1", mode, field, k, pulses);
    else passed++;
    bp = 0; tick(); bp = 1; tick();
    total++;
    if (k !== 8'd17 || upd !== 1'b1) $display("FAIL override_repress: got k %0d upd %0d want 17 1", k, upd);
    else passed++;
    bp = 0;
    tick();
  endtask

  task automatic test_enable();
    en = 0;
    bp = 1;
    pulses = 0;
    for (int i = 0; i < 10; i++) tick();
    bm = 1; tick(); bm = 0; tick();
    en = 1;
    for (int i = 0; i < 30; i++) begin
      tick();
      total++;
      if (obs !== expv()) $display("FAIL enable_hold cyc%0d: got %h want %h", i, obs, expv());
      else passed++;
    end
    total++;
    if (pulses !== 0 || k !== 8'd17 || mode !== 2'd2) $display("FAIL enable_gate: got pulses %0d k %0d mode %0d want 0 17 2", pulses, k, mode);
    else passed++;
    bp = 0; tick(); bp = 1; tick();
    total++;
    if (k !== 8'd18) $display("FAIL enable_repress: got %0d want 18", k);
    else passed++;
    bp = 0;
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 4000; i++) begin
      rst = $urandom_range(999) == 0;
      if ($urandom_range(199) == 0) en = ~en;
      if ($urandom_range(59) == 0) bm = ~bm;
      if ($urandom_range(29) == 0) bf = ~bf;
      if ($urandom_range(39) == 0) bp = ~bp;
      if ($urandom_range(39) == 0) bn = ~bn;
      tick();
      total++;
      if (obs !== expv()) $display("FAIL random cyc%0d: got %h want %h", i, obs, expv());
      else passed++;
    end
    rst = 0;
  endtask

  initial begin
    test_reset();
    test_angle_repeat();
    test_angle_clamp();
    test_sine();
    test_mode_override();
    test_enable();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
